// File: rtl/ep2_port_demux.sv
// ep2_port_demux: parses the EP2 host byte stream into {port, len_hi, len_lo,
// payload} packets and steers each payload byte into one of NUM_PORTS
// asynchronous FIFOs. It also publishes each FIFO's write pointer and a
// per-port cumulative byte count for the memory arbitrator.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   ep2_data/valid    - incoming stream byte and its valid
//   ep2_ready         - byte accepted on edges where ep2_valid && ep2_ready
//   fifo_in_addrs     - per-port write pointer, ADDR_WIDTH bits per port
//   fifo_out_addrs    - per-port read pointer, already synchronized to clk
//   fifo_write_datas  - per-port write data, 8 bits per port
//   fifo_write        - per-port write strobe (at most one high)
//   byte_counts       - per-port cumulative byte count, 32 bits per port
//   bad_header        - one-cycle pulse after a port byte with stray high bits
module ep2_port_demux #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [7:0]                      ep2_data,
  input  logic                            ep2_valid,
  output logic                            ep2_ready,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0] fifo_in_addrs,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] fifo_out_addrs,
  output logic [NUM_PORTS*8-1:0]          fifo_write_datas,
  output logic [NUM_PORTS-1:0]            fifo_write,
  output logic [NUM_PORTS*32-1:0]         byte_counts,
  output logic                            bad_header
);

  localparam int unsigned PW = $clog2(NUM_PORTS);

  typedef enum logic [2:0] {
    HDR_PORT,
    HDR_LEN_HI,
    HDR_LEN_LO,
    PAYLOAD,
    DISCARD
  } state_e;

  state_e                               state_q, state_d;
  logic [PW-1:0]                        port_q, port_d;
  logic                                 bad_q, bad_d;
  logic [15:0]                          rem_q, rem_d;
  logic                                 bad_pulse_q, bad_pulse_d;
  logic [NUM_PORTS-1:0]                 wr_q, wr_d;
  logic [NUM_PORTS-1:0][7:0]            wdata_q, wdata_d;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
  logic [NUM_PORTS-1:0][31:0]           cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]                 full_c;
  logic                                 ready_c;
  logic                                 accept_c;
  logic [15:0]                          len_c;

  // A pending strobe counts as occupied, so one slot always stays free.
  always_comb begin
    full_c = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      full_c[p] = (in_addr_q[p] + ADDR_WIDTH'(wr_q[p]) + ADDR_WIDTH'(1))
                  == fifo_out_addrs[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Only the payload phase can back-pressure the host.
  always_comb begin
    ready_c = 1'b0;
    if (!reset) begin
      ready_c = (state_q == PAYLOAD) ? !full_c[port_q] : 1'b1;
    end
  end

  assign accept_c = ep2_valid && ready_c;
  assign len_c    = {rem_q[15:8], ep2_data};

  // Next-state, write strobes and pointer/count updates.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    bad_d       = bad_q;
    rem_d       = rem_q;
    bad_pulse_d = 1'b0;
    wr_d        = '0;
    wdata_d     = wdata_q;
    in_addr_d   = in_addr_q;
    cnt_d       = cnt_q;

    // The strobe issued last cycle retires on this edge.
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (wr_q[p]) begin
        in_addr_d[p] = in_addr_q[p] + ADDR_WIDTH'(1);
        cnt_d[p]     = cnt_q[p] + 32'd1;
      end
    end

    case (state_q)
      HDR_PORT: begin
        if (accept_c) begin
          port_d      = ep2_data[PW-1:0];
          bad_d       = (ep2_data[7:PW] != '0);
          bad_pulse_d = (ep2_data[7:PW] != '0);
          state_d     = HDR_LEN_HI;
        end
      end
      HDR_LEN_HI: begin
        if (accept_c) begin
          rem_d[15:8] = ep2_data;
          state_d     = HDR_LEN_LO;
        end
      end
      HDR_LEN_LO: begin
        if (accept_c) begin
          rem_d = len_c;
          if (len_c == 16'd0) begin
            state_d = HDR_PORT;
          end else if (bad_q) begin
            state_d = DISCARD;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept_c) begin
          wr_d[port_q]    = 1'b1;
          wdata_d[port_q] = ep2_data;
          rem_d           = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = HDR_PORT;
          end
        end
      end
      DISCARD: begin
        if (accept_c) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = HDR_PORT;
          end
        end
      end
      default: state_d = HDR_PORT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR_PORT;
      port_q      <= '0;
      bad_q       <= 1'b0;
      rem_q       <= '0;
      bad_pulse_q <= 1'b0;
      wr_q        <= '0;
      wdata_q     <= '0;
      in_addr_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      bad_q       <= bad_d;
      rem_q       <= rem_d;
      bad_pulse_q <= bad_pulse_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      in_addr_q   <= in_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ep2_ready        = ready_c;
  assign fifo_in_addrs    = in_addr_q;
  assign fifo_write_datas = wdata_q;
  assign fifo_write       = wr_q;
  assign byte_counts      = cnt_q;
  assign bad_header       = bad_pulse_q;

endmodule

// File: tb/tb_ep2_port_demux.sv
// tb_ep2_port_demux: drives packets into ep2_port_demux. A packet-level model
// predicts every FIFO write (port, address, byte) into a queue; a negedge
// monitor pops and compares each observed strobe. Pointer, count and
// bad-header totals are compared against the model at quiet points.
module tb_ep2_port_demux;

  localparam int unsigned NP      = 4;
  localparam int unsigned AW      = 11;
  localparam int          TIMEOUT = 300;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           ep2_data;
  logic                 ep2_valid;
  logic                 ep2_ready;
  logic [NP*AW-1:0]     fifo_in_addrs;
  logic [NP*AW-1:0]     fifo_out_addrs;
  logic [NP*8-1:0]      fifo_write_datas;
  logic [NP-1:0]        fifo_write;
  logic [NP*32-1:0]     byte_counts;
  logic                 bad_header;

  always #5 clk = ~clk;

  ep2_port_demux #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .ep2_data         (ep2_data),
    .ep2_valid        (ep2_valid),
    .ep2_ready        (ep2_ready),
    .fifo_in_addrs    (fifo_in_addrs),
    .fifo_out_addrs   (fifo_out_addrs),
    .fifo_write_datas (fifo_write_datas),
    .fifo_write       (fifo_write),
    .byte_counts      (byte_counts),
    .bad_header       (bad_header)
  );

  typedef struct packed {
    logic [1:0]    port;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  int          bad_exp = 0;
  int          bad_seen = 0;
  bit          gaps = 1'b0;
  wr_t         exp_q[$];
  logic [7:0]  pay[$];
  logic [AW-1:0] mdl_addr[NP];
  logic [31:0]   mdl_cnt[NP];
  wr_t         mon_a;
  wr_t         mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every observed strobe must match the next prediction.
  always @(negedge clk) begin
    if (bad_header) bad_seen++;
    if (fifo_write != '0) begin
      check("one_strobe", 64'($countones(fifo_write)), 64'd1);
      for (int p = 0; p < NP; p++) begin
        if (fifo_write[p]) begin
          mon_a.port = 2'(p);
          mon_a.addr = fifo_in_addrs[p*AW +: AW];
          mon_a.data = fifo_write_datas[p*8 +: 8];
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %0h required none", mon_a);
          end else begin
            mon_e = exp_q.pop_front();
            check("write", 64'(mon_a), 64'(mon_e));
          end
        end
      end
    end
  end

  // Packet-level reference: a good header with nonzero length puts each
  // payload byte at the next address of its port.
  task automatic model_pkt(input logic [7:0] pb, input int len);
    wr_t e;
    if (pb[7:2] != 6'd0) begin
      bad_exp++;
    end else begin
      for (int i = 0; i < len; i++) begin
        e.port = pb[1:0];
        e.addr = mdl_addr[pb[1:0]];
        e.data = pay[i];
        exp_q.push_back(e);
        mdl_addr[pb[1:0]] = mdl_addr[pb[1:0]] + AW'(1);
        mdl_cnt[pb[1:0]]  = mdl_cnt[pb[1:0]] + 32'd1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  acc;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      ep2_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    ep2_data  = b;
    ep2_valid = 1'b1;
    while (!ok && n < TIMEOUT) begin
      #1 acc = ep2_ready;
      @(negedge clk);
      if (acc) ok = 1'b1;
      n++;
    end
    ep2_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %0h not accepted within %0d cycles", b, TIMEOUT);
    end
  endtask

  task automatic tx_pkt(input logic [7:0] pb, input int len);
    model_pkt(pb, len);
    send_byte(pb);
    send_byte(8'(len >> 8));
    send_byte(8'(len));
    for (int i = 0; i < len; i++) send_byte(pay[i]);
  endtask

  task automatic fill_pay(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
  endtask

  task automatic set_out(input int p, input logic [AW-1:0] v);
    fifo_out_addrs[p*AW +: AW] = v;
  endtask

  task automatic check_state(input string tag);
    repeat (3) @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      check({tag, "_in_addr"}, 64'(fifo_in_addrs[p*AW +: AW]), 64'(mdl_addr[p]));
      check({tag, "_count"},   64'(byte_counts[p*32 +: 32]),   64'(mdl_cnt[p]));
    end
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_bad_hdr"}, 64'(bad_seen), 64'(bad_exp));
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    ep2_valid      = 1'b0;
    fifo_out_addrs = '0;
    repeat (2) @(negedge clk);
    #1 check("ready_in_reset", 64'(ep2_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int p = 0; p < NP; p++) begin
      mdl_addr[p] = '0;
      mdl_cnt[p]  = '0;
    end
  endtask

  initial begin
    ep2_data       = '0;
    ep2_valid      = 1'b0;
    fifo_out_addrs = '0;
    reset          = 1'b1;
    for (int p = 0; p < NP; p++) begin
      mdl_addr[p] = '0;
      mdl_cnt[p]  = '0;
    end
    do_reset();
    check("rst_write",  64'(fifo_write), 64'd0);
    check("rst_wdata",  64'(fifo_write_datas), 64'd0);
    check("rst_bad",    64'(bad_header), 64'd0);
    check("rst_addrs",  64'(fifo_in_addrs), 64'd0);
    check("rst_counts", 64'(byte_counts != '0), 64'd0);
    #1 check("ready_after_reset", 64'(ep2_ready), 64'd1);

    // Basic write to port 2.
    pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    tx_pkt(8'h02, 4);
    check_state("port2");

    // Zero length packet, then a one-byte packet.
    pay.delete();
    tx_pkt(8'h01, 0);
    pay = '{8'h55};
    tx_pkt(8'h03, 1);
    check_state("zero_len");

    // Bad header payload is dropped; the next packet still parses.
    pay = '{8'h11, 8'h22};
    tx_pkt(8'h84, 2);
    check_state("bad_hdr");
    pay = '{8'h77};
    tx_pkt(8'h00, 1);
    check_state("after_bad");

    // Full stall on port 1 with the read pointer parked at 0.
    do_reset();
    fill_pay(3000);
    model_pkt(8'h01, 3000);
    send_byte(8'h01);
    send_byte(8'h0B);
    send_byte(8'hB8);
    for (int i = 0; i < 2047; i++) send_byte(pay[i]);
    ep2_data  = pay[2047];
    ep2_valid = 1'b1;
    repeat (10) @(negedge clk);
    #1 check("stall_ready", 64'(ep2_ready), 64'd0);
    check("stall_in_addr", 64'(fifo_in_addrs[1*AW +: AW]), 64'd2047);
    check("stall_pending", 64'(exp_q.size()), 64'd953);
    set_out(1, AW'(100));
    for (int i = 2047; i < 2097; i++) send_byte(pay[i]);
    set_out(1, AW'(1500));
    for (int i = 2097; i < 3000; i++) send_byte(pay[i]);
    check_state("full_stall");

    // Pointer wrap on port 0.
    fill_pay(2046);
    tx_pkt(8'h00, 2046);
    check_state("preload");
    set_out(0, AW'(1000));
    fill_pay(3);
    tx_pkt(8'h00, 3);
    check_state("ptr_wrap");

    // Byte count wrap on port 0.
    @(negedge clk);
    dut.cnt_q[0] = 32'hFFFF_FFFF;
    mdl_cnt[0]   = 32'hFFFF_FFFF;
    fill_pay(1);
    tx_pkt(8'h00, 1);
    check_state("cnt_wrap");

    // Reset in the middle of a payload to port 3.
    fill_pay(4);
    model_pkt(8'h03, 2);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(pay[0]);
    send_byte(pay[1]);
    do_reset();
    check_state("mid_reset");
    pay = '{8'h9A};
    tx_pkt(8'h03, 1);
    check_state("post_reset");

    // Randomized packets with valid gaps; read pointers kept well ahead.
    gaps = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] pb;
      int         len;
      for (int p = 0; p < NP; p++) set_out(p, mdl_addr[p] + AW'(1024));
      pb = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) pb[7:2] = 6'($urandom_range(1, 63));
      len = $urandom_range(0, 24);
      fill_pay(len);
      tx_pkt(pb, len);
    end
    check_state("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ep2_port_demux.md
Name: ep2_port_demux

Overview:
- Upstream feeder for the memory arbitrator's EP2 write ports.
- Parses the host byte stream from EP2 into packets of the form port byte, 16-bit length, then payload.
- Routes each payload into one of NUM_PORTS per-port asynchronous FIFOs.
- Publishes each FIFO's write pointer and a per-port cumulative byte count, which the arbitrator latches when it computes its write delta.

Parameters:
- NUM_PORTS, 4, number of destination FIFOs; port field width is log2(NUM_PORTS).
- ADDR_WIDTH, 11, FIFO pointer width (2048-byte FIFOs).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- ep2_data  input  8  stream byte.
- ep2_valid  input  1  ep2_data valid.
- ep2_ready  output  1  a byte is accepted on an edge where ep2_valid && ep2_ready.
- fifo_in_addrs  output  NUM_PORTS*ADDR_WIDTH  per-port write pointer, port p at bits [(p+1)*ADDR_WIDTH-1 : p*ADDR_WIDTH].
- fifo_out_addrs  input  NUM_PORTS*ADDR_WIDTH  per-port read pointer (already synchronized to clk).
- fifo_write_datas  output  NUM_PORTS*8  per-port write data, same packing with 8-bit lanes.
- fifo_write  output  NUM_PORTS  per-port write strobe.
- byte_counts  output  NUM_PORTS*32  cumulative bytes written per port.
- bad_header  output  1  one-cycle pulse on an invalid port byte.

Behaviour:
Reset:
- State is HDR_PORT.
- All fifo_in_addrs, fifo_write_datas, fifo_write, byte_counts and bad_header are 0.
- ep2_ready is 0 while reset is high.
- Reset mid-packet discards the partial packet. The FIFOs must be reset in the same cycle.

State machine:
- HDR_PORT: ready=1. On accept, latch port=data[log2 NUM_PORTS-1:0].
  - If data[7:log2 NUM_PORTS] != 0, set bad flag and pulse bad_header on the next cycle.
  - Go to HDR_LEN_HI.
- HDR_LEN_HI: ready=1. On accept, len[15:8]=data. Go to HDR_LEN_LO.
- HDR_LEN_LO: ready=1. On accept, len[7:0]=data. Next state:
  - len==0 → HDR_PORT;
  - bad flag set → DISCARD;
  - otherwise → PAYLOAD.
- PAYLOAD: ready = !full[port]. On accept, decrement remaining; after the last byte go to HDR_PORT.
- DISCARD: ready=1. Consume len bytes with no FIFO writes and no count changes, then go to HDR_PORT.

Write timing:
- Accept at edge N drives, for the cycle after N: fifo_write_data[port]=byte and fifo_write[port]=1, with fifo_in_addr[port] still holding the target address.
- At edge N+1: fifo_in_addr[port] increments modulo 2^ADDR_WIDTH, and byte_counts[port] increments modulo 2^32.
- A back-to-back accept at N+1 keeps the strobe high for another cycle with the new data.
- Only one port's strobe is ever high.

Full and wrap rules:
- full[p] = ((fifo_in_addr[p] + fifo_write[p] + 1) mod 2^ADDR_WIDTH) == fifo_out_addr[p].
- The pending write is counted, so usable capacity is 2^ADDR_WIDTH-1 = 2047 bytes.
- Empty (in==out) has no effect on this block.
- Pointer wrap is natural modular arithmetic; byte_counts wrap at 2^32 silently.
- Lengths 1..65535 are legal and independent of FIFO size; payload simply stalls on full.
- ep2_valid low mid-packet is a pause, not an abort; there is no timeout.

Test Plan:
1. Port 2 write: stream 02 00 04 AA BB CC DD, out_addr=0.
   - Required: four single-cycle strobes on lane 2 with AA..DD at addresses 0..3.
   - Required end state: fifo_in_addr[2]=4, byte_counts[2]=4; other ports unchanged.
2. Zero length: stream 01 00 00 then 03 00 01 55.
   - Required: no write to port 1.
   - Required: port 3 receives 55 at address 0 and byte_counts[3]=1.
3. Bad header: stream 84 00 02 11 22 then 00 00 01 77.
   - Required: bad_header pulses once, 11 and 22 are dropped, no counts change.
   - Required: port 0 then receives 77.
4. Full stall: port 1 with out_addr[1]=0 held, length 3000, ep2_valid held high.
   - Required: exactly 2047 bytes written, then ep2_ready=0 and in_addr[1]=2047.
   - Required: after out_addr[1] is set to 100, transfer resumes and the remaining bytes complete.
5. Pointer and count wrap:
   - Preload traffic so in_addr[0]=2046, then write 3 bytes with out_addr kept ahead → addresses 2046, 2047, 0, and in_addr[0]=1.
   - Force byte_counts[0]=FFFFFFFF, then write 1 byte → byte_counts[0]=0.
6. Reset mid-payload: assert reset after 2 of 4 payload bytes to port 3.
   - Required: all pointers and counts read 0.
   - Required: a subsequent full packet 03 00 01 9A parses from a clean header.
